// File: rtl/vmask_reduce_if.sv
// Handshake/bus bundle between the vector ALU chunk streamer and the mask-reduction sequencer.
// master drives chunks and operation controls; slave returns busy and the scalar result strobe.
interface vmask_reduce_if #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64
);
  logic                       in_valid;
  logic                       in_start;
  logic                       in_last;
  logic                       in_op;
  logic                       in_vm;
  logic [RESP_DATA_WIDTH-1:0] in_vl;
  logic [REQ_DATA_WIDTH-1:0]  in_vs2;
  logic [REQ_DATA_WIDTH-1:0]  in_m0;
  logic                       busy;
  logic                       out_valid;
  logic [RESP_DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_start, in_last, in_op, in_vm, in_vl, in_vs2, in_m0,
    input  busy, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_start, in_last, in_op, in_vm, in_vl, in_vs2, in_m0,
    output busy, out_valid, out_data
  );
endinterface

// File: rtl/vmask_reduce.sv
// vcpop.m / vfirst.m sequencer: v0 and vl-tail masking per chunk, 2-stage reduce, one result strobe.
// Latency: last chunk at edge E -> out_valid during the cycle after E+2; no stalls, in_start aborts.
module vmask_reduce #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int DATA_WIDTH_BITS = $clog2(REQ_DATA_WIDTH)
) (
  input logic          clk,
  input logic          rst,
  vmask_reduce_if.slave bus
);
  localparam int PC_W = DATA_WIDTH_BITS + 1;

  typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;

  state_t                     state_q, state_d;
  logic                       op_q, vm_q;
  logic [RESP_DATA_WIDTH-1:0] vl_q, base_q;
  logic                       s1_vld_q, s1_last_q;
  logic [REQ_DATA_WIDTH-1:0]  s1_eff_q;
  logic [RESP_DATA_WIDTH-1:0] s1_base_q;
  logic [RESP_DATA_WIDTH-1:0] count_q, first_q;
  logic                       found_q, s2_last_q;
  logic                       out_valid_q;
  logic [RESP_DATA_WIDTH-1:0] out_data_q;

  logic                       start_acc, accept, cur_vm;
  logic [RESP_DATA_WIDTH-1:0] cur_base, cur_vl;
  logic [REQ_DATA_WIDTH-1:0]  tail, eff;
  logic [PC_W-1:0]            pc;
  logic [DATA_WIDTH_BITS-1:0] lsb_idx;

  // A start chunk uses its own controls directly since the latched copies are not yet valid.
  assign start_acc = bus.in_valid & bus.in_start;
  assign accept    = start_acc | (bus.in_valid & (state_q == ACC));
  assign cur_vm    = start_acc ? bus.in_vm : vm_q;
  assign cur_vl    = start_acc ? bus.in_vl : vl_q;
  assign cur_base  = start_acc ? '0 : base_q;

  always_comb begin
    tail = '0;
    for (int i = 0; i < REQ_DATA_WIDTH; i++) begin
      tail[i] = (cur_base + RESP_DATA_WIDTH'(i)) < cur_vl;
    end
  end

  assign eff = bus.in_vs2 & (cur_vm ? {REQ_DATA_WIDTH{1'b1}} : bus.in_m0) & tail;

  always_comb begin
    pc      = '0;
    lsb_idx = '0;
    for (int i = REQ_DATA_WIDTH - 1; i >= 0; i--) begin
      pc = pc + PC_W'(s1_eff_q[i]);
      if (s1_eff_q[i]) lsb_idx = DATA_WIDTH_BITS'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      ACC:     if (bus.in_valid && bus.in_last) state_d = FLUSH;
      FLUSH:   if (out_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_acc) state_d = bus.in_last ? FLUSH : ACC;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      vm_q        <= 1'b0;
      vl_q        <= '0;
      base_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_eff_q    <= '0;
      s1_base_q   <= '0;
      count_q     <= '0;
      first_q     <= '0;
      found_q     <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        op_q <= bus.in_op;
        vm_q <= bus.in_vm;
        vl_q <= bus.in_vl;
      end
      if (accept) base_q <= cur_base + RESP_DATA_WIDTH'(REQ_DATA_WIDTH);

      s1_vld_q  <= accept;
      s1_last_q <= accept & bus.in_last;
      s1_eff_q  <= accept ? eff : '0;
      s1_base_q <= cur_base;

      // A new start discards whatever the old operation still has in stage 2.
      if (start_acc) begin
        count_q   <= '0;
        first_q   <= '0;
        found_q   <= 1'b0;
        s2_last_q <= 1'b0;
      end else begin
        s2_last_q <= s1_vld_q & s1_last_q;
        if (s1_vld_q) begin
          if (!op_q) begin
            count_q <= count_q + RESP_DATA_WIDTH'(pc);
          end else if (!found_q && (s1_eff_q != '0)) begin
            first_q <= s1_base_q + RESP_DATA_WIDTH'(lsb_idx);
            found_q <= 1'b1;
          end
        end
      end

      out_valid_q <= s2_last_q & ~start_acc;
      if (s2_last_q && !start_acc) begin
        out_data_q <= op_q ? (found_q ? first_q : {RESP_DATA_WIDTH{1'b1}}) : count_q;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_vmask_reduce.sv
// Directed bench for vmask_reduce: hand-computed vcpop/vfirst results, latency, abort and reset.
module tb_vmask_reduce;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vmask_reduce_if #(.REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64)) bus ();

  vmask_reduce #(.REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit st, input bit ls, input bit op, input bit vm,
                      input logic [63:0] vl, input logic [63:0] vs2, input logic [63:0] m0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_start = st;
    bus.in_last  = ls;
    bus.in_op    = op;
    bus.in_vm    = vm;
    bus.in_vl    = vl;
    bus.in_vs2   = vs2;
    bus.in_m0    = m0;
  endtask

  // Called right after the last chunk was driven; watches a bounded window of negedges.
  task automatic wait_result(input string tag, input logic [63:0] exp);
    int          strobes = 0;
    int          lat = 0;
    logic [63:0] data = '0;
    logic        busy1 = 1'b0;
    logic        busy_after = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.in_valid = 1'b0;
        busy1 = bus.busy;
      end
      if (lat != 0 && k == lat + 1) busy_after = bus.busy;
      if (bus.out_valid) begin
        strobes++;
        if (lat == 0) begin
          lat  = k;
          data = bus.out_data;
        end
      end
    end
    check({tag, "_strobes"}, 64'(strobes), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_data"}, data, exp);
    check({tag, "_busy_rise"}, 64'(busy1), 64'd1);
    check({tag, "_busy_fall"}, 64'(busy_after), 64'd0);
  endtask

  initial begin
    int strobes;
    n_cmp = 0;
    n_err = 0;
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_op    = 1'b0;
    bus.in_vm    = 1'b0;
    bus.in_vl    = '0;
    bus.in_vs2   = '0;
    bus.in_m0    = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // vcpop, unmasked, single chunk
    send(1, 1, 0, 1, 64'd64, 64'h0000_0000_0000_00FF, 64'd0);
    wait_result("cpop_ff", 64'd8);
    // vcpop, v0 masked
    send(1, 1, 0, 0, 64'd64, 64'hFF, 64'h0F);
    wait_result("cpop_m0", 64'd4);
    // vcpop, tail masking in the second chunk
    send(1, 0, 0, 1, 64'd100, ONES, 64'd0);
    send(0, 1, 0, 1, 64'd100, ONES, 64'd0);
    wait_result("cpop_vl100", 64'd100);
    // vfirst found in second chunk
    send(1, 0, 1, 1, 64'd128, 64'd0, 64'd0);
    send(0, 1, 1, 1, 64'd128, 64'h8, 64'd0);
    wait_result("first_67", 64'd67);
    // vfirst with nothing set
    send(1, 0, 1, 1, 64'd128, 64'd0, 64'd0);
    send(0, 1, 1, 1, 64'd128, 64'd0, 64'd0);
    wait_result("first_none", ONES);
    // vl = 0 counts nothing
    send(1, 1, 0, 1, 64'd0, ONES, 64'd0);
    wait_result("cpop_vl0", 64'd0);
    // vfirst keeps the first hit and ignores later chunks
    send(1, 0, 1, 1, 64'd128, 64'h100, 64'd0);
    send(0, 1, 1, 1, 64'd128, 64'h1, 64'd0);
    wait_result("first_keep", 64'd8);
    // vfirst through v0 mask
    send(1, 1, 1, 0, 64'd64, 64'hFF, 64'hF0);
    wait_result("first_m0", 64'd4);
    // vfirst where the only set bit is in the tail
    send(1, 1, 1, 1, 64'd3, 64'h8, 64'd0);
    wait_result("first_tail", ONES);
    // abort mid-operation
    send(1, 0, 0, 1, 64'd128, ONES, 64'd0);
    send(1, 1, 0, 1, 64'd64, 64'h3, 64'd0);
    wait_result("abort_mid", 64'd2);
    // abort of an operation whose last chunk is already in the pipeline
    send(1, 1, 0, 1, 64'd64, ONES, 64'd0);
    send(1, 1, 0, 1, 64'd64, 64'h7, 64'd0);
    wait_result("abort_last", 64'd3);

    // reset in the middle of an operation
    send(1, 0, 0, 1, 64'd128, ONES, 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data", bus.out_data, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    // chunk without start in IDLE must be ignored as well
    send(0, 1, 0, 1, 64'd64, ONES, 64'd0);
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) strobes++;
    end
    check("post_rst_strobes", 64'(strobes), 64'd0);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vmask_reduce.md
# vmask_reduce

Mask-reduction sequencer for the vector ALU that implements vcpop.m and vfirst.m over a mask register streamed in REQ_DATA_WIDTH-bit chunks. It applies v0 masking and vl tail masking to each chunk and keeps a running element base. For vcpop it registers the masked chunk and the running count into the popcount/add stage; for vfirst it tracks the first set element. It emits one scalar result per operation on a single-cycle valid pulse toward the writeback path.

## Interface
- REQ_DATA_WIDTH, 64, mask chunk width in elements (bits)
- RESP_DATA_WIDTH, 64, width of scalar result, vl and element counters
- DATA_WIDTH_BITS, $clog2(REQ_DATA_WIDTH), bit-index width within a chunk

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset; 0 clears all state immediately
- in_valid  input  1  chunk present this cycle
- in_start  input  1  qualifies in_valid: first chunk of a new operation
- in_last  input  1  qualifies in_valid: final chunk of the operation
- in_op  input  1  0 = vcpop, 1 = vfirst; sampled with in_start
- in_vm  input  1  1 = unmasked (ignore v0); sampled with in_start
- in_vl  input  RESP_DATA_WIDTH  active vector length; sampled with in_start
- in_vs2  input  REQ_DATA_WIDTH  source mask chunk
- in_m0  input  REQ_DATA_WIDTH  matching v0 chunk
- busy  output  1  operation in flight
- out_valid  output  1  one-cycle result strobe
- out_data  output  RESP_DATA_WIDTH  result; held until next strobe

## Operation
- States: IDLE, ACC, FLUSH.
  - IDLE: in_valid&in_start latches op/vm/vl, sets base=0, count=0, found=0. Goes to ACC, or to FLUSH if in_last is also set.
  - ACC: each in_valid chunk is processed and base += REQ_DATA_WIDTH. A chunk with in_last goes to FLUSH.
  - FLUSH: two cycles of pipeline drain, then out_valid, then IDLE.
- Per chunk: eff = in_vs2 & (in_vm ? all-ones : in_m0) & tail.
  - tail bit i = (base + i < vl).
  - Chunks entirely at or beyond vl contribute zero.
- Stage 1 registers eff, count, base and a last flag.
- Stage 2, vcpop: count_next = count + popcount(eff).
- Stage 2, vfirst: if found=0 and eff≠0, result = base + index of lowest set bit, and found=1. Later chunks are ignored once found=1.
- Result:
  - vcpop: final count.
  - vfirst: recorded index, or all-ones (-1) if no bit was ever found.
- Arithmetic: base and count are RESP_DATA_WIDTH bits, unsigned, and wrap modulo 2^RESP_DATA_WIDTH. Per-chunk popcount is DATA_WIDTH_BITS+1 bits wide so it can represent a full chunk of REQ_DATA_WIDTH.
- in_start asserted while busy aborts the current operation:
  - pipeline contents of the old operation are discarded;
  - no out_valid is produced for the aborted operation;
  - the new operation starts as if from IDLE.
- in_valid without in_start in IDLE is ignored.
- in_start and in_last are don't-care when in_valid=0.
- Upstream guarantees no new in_start after in_last until out_valid. A violation is handled as an abort.

## Timing
- Reset (rst=0), immediately: state=IDLE, busy=0, out_valid=0, out_data=0, all pipeline registers and counters 0.
- Reset during an operation abandons it; no result is produced.
- Throughput: one chunk per cycle, with no stalls inside an operation.
- Latency: the last chunk is sampled at edge E. out_valid is high for exactly the cycle following edge E+2.
- busy rises the cycle after the in_start chunk is sampled. It falls in the same cycle that out_valid deasserts.
- vl=0: vcpop result is 0; vfirst result is all-ones.
- vl larger than the number of supplied chunks: only supplied chunks count. in_last terminates the operation.
- out_data changes only on the edge that raises out_valid.

## Test plan
- vcpop, vm=1, vl=64, one chunk vs2=0x00000000000000FF with start+last → out_valid 3 cycles later, out_data=8.
- vcpop, vm=0, m0=0x0F, vs2=0xFF, vl=64 → out_data=4.
- vcpop, vm=1, vl=100, two chunks of all-ones → out_data=100 (second-chunk tail bits 36..63 masked).
- vfirst, vm=1, vl=128, chunk0=0, chunk1=0x8 → out_data=67. Then vs2 all zero → out_data=0xFFFF_FFFF_FFFF_FFFF.
- Abort: start vcpop, send 1 chunk of all-ones, then new start+last with vs2=0x3 → only one out_valid, out_data=2.
- Assert rst=0 mid-operation → busy, out_valid and out_data go to 0 immediately. No strobe after release until a new start.
